// File: rtl/apb_slave_viol_checker.sv
// APB3 slave with a register-file memory, programmable wait states and an
// on-the-fly protocol checker reporting sticky violation flags and a saturating count.
module apb_slave_viol_checker #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 64,
    parameter int WAIT_STATES = 0,
    parameter int CNT_W       = 8
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [DATA_W-1:0] PWDATA,
    output logic [DATA_W-1:0] PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    input  logic              viol_clr,
    output logic [3:0]        viol_flags,
    output logic [CNT_W-1:0]  viol_count
);

    localparam int IDX_W  = ADDR_W - 2;
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t              state_r;
    logic [ADDR_W-1:0]   addr_r;
    logic                wr_r;
    logic [DATA_W-1:0]   wd_r;
    logic [3:0]          wait_cnt_r;
    logic                chg_r;
    logic [DATA_W-1:0]   mem_r [DEPTH];
    logic [3:0]          flags_r;
    logic [CNT_W-1:0]    count_r;

    logic [IDX_W-1:0]    idx_s;
    logic [MEM_AW-1:0]   mem_idx_s;
    logic                in_range_s;
    logic                access_s;
    logic                en_sel_s;
    logic                chg_now_s;
    logic [3:0]          viol_ev_s;
    logic                err_s;
    logic                pready_s;
    logic                commit_s;
    logic [DATA_W-1:0]   rdata_s;

    // Transfer decode, violation detection and completion response.
    always_comb begin
        idx_s      = addr_r[ADDR_W-1:2];
        mem_idx_s  = MEM_AW'(idx_s);
        in_range_s = (32'(idx_s) < 32'(DEPTH));
        access_s   = (state_r == ACCESS);
        en_sel_s   = PSEL & PENABLE;
        chg_now_s  = access_s & en_sel_s &
                     ((PADDR != addr_r) | (PWRITE != wr_r) | (wr_r & (PWDATA != wd_r)));

        // The four events are mutually exclusive, so at most one counts per cycle.
        viol_ev_s[0] = (state_r == IDLE) & en_sel_s;
        viol_ev_s[1] = access_s & PSEL & ~PENABLE;
        viol_ev_s[2] = chg_now_s & ~chg_r;
        viol_ev_s[3] = access_s & ~PSEL;

        // A change seen on the completing cycle itself must still poison it.
        err_s    = ~in_range_s | chg_r | chg_now_s;
        pready_s = access_s & en_sel_s & (wait_cnt_r == 4'd0);
        commit_s = pready_s & wr_r & ~err_s;

        if (pready_s && !wr_r && !err_s) begin
            rdata_s = mem_r[mem_idx_s];
        end else begin
            rdata_s = '0;
        end
    end

    assign PREADY     = pready_s;
    assign PSLVERR    = pready_s & err_s;
    assign PRDATA     = rdata_s;
    assign viol_flags = flags_r;
    assign viol_count = count_r;

    // Transfer FSM: setup capture, wait-state countdown, completion or abort.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_r    <= IDLE;
            addr_r     <= '0;
            wr_r       <= 1'b0;
            wd_r       <= '0;
            wait_cnt_r <= 4'd0;
            chg_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (PSEL && !PENABLE) begin
                        addr_r     <= PADDR;
                        wr_r       <= PWRITE;
                        wd_r       <= PWDATA;
                        wait_cnt_r <= 4'(WAIT_STATES);
                        chg_r      <= 1'b0;
                        state_r    <= ACCESS;
                    end else begin
                        state_r    <= IDLE;
                    end
                end
                ACCESS: begin
                    if (en_sel_s) begin
                        if (chg_now_s) begin
                            chg_r <= 1'b1;
                        end else begin
                            chg_r <= chg_r;
                        end
                        if (wait_cnt_r != 4'd0) begin
                            wait_cnt_r <= wait_cnt_r - 4'd1;
                        end else begin
                            state_r    <= IDLE;
                        end
                    end else begin
                        // Aborted transfer; the abort cycle is never a new setup.
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Register file; cleared on reset, written only by an error-free completing write.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (commit_s) begin
            mem_r[mem_idx_s] <= wd_r;
        end else begin
            mem_r[mem_idx_s] <= mem_r[mem_idx_s];
        end
    end

    // Sticky flags and saturating event count; clear wins over a same-cycle event.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            flags_r <= 4'd0;
            count_r <= '0;
        end else if (viol_clr) begin
            flags_r <= 4'd0;
            count_r <= '0;
        end else begin
            flags_r <= flags_r | viol_ev_s;
            if ((viol_ev_s != 4'd0) && (count_r != {CNT_W{1'b1}})) begin
                count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                count_r <= count_r;
            end
        end
    end

endmodule

// File: tb/tb_apb_slave_viol_checker.sv
// Randomised scoreboard bench for apb_slave_viol_checker: a transfer-level model
// predicts each completion (cycle, data, error) plus violation flags and count.
module tb_apb_slave_viol_checker;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 64;
    localparam int WS     = 2;
    localparam int CNT_W  = 8;

    logic              PCLK = 1'b0;
    logic              PRESETn = 1'b0;
    logic              PSEL = 1'b0;
    logic              PENABLE = 1'b0;
    logic              PWRITE = 1'b0;
    logic [ADDR_W-1:0] PADDR = '0;
    logic [DATA_W-1:0] PWDATA = '0;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;
    logic              PSLVERR;
    logic              viol_clr = 1'b0;
    logic [3:0]        viol_flags;
    logic [CNT_W-1:0]  viol_count;

    apb_slave_viol_checker #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .WAIT_STATES(WS), .CNT_W(CNT_W)
    ) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .viol_clr(viol_clr), .viol_flags(viol_flags), .viol_count(viol_count)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        int          cyc;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        e;
    logic [31:0] m_mem [DEPTH];
    logic [3:0]  m_flags;
    int          m_cnt;
    int          cyc = 0;
    int          tests = 0;
    int          fails = 0;

    always @(posedge PCLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every PREADY pops one expected completion; otherwise outputs must be 0.
    always @(negedge PCLK) begin
        if (PRESETn) begin
            if (PREADY) begin
                if (sb_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_pready: got 1 expected 0 (cycle %0d)", cyc);
                end else begin
                    e = sb_q.pop_front();
                    check("latency", 64'(cyc), 64'(e.cyc));
                    check("prdata", 64'(PRDATA), 64'(e.data));
                    check("pslverr", 64'(PSLVERR), 64'(e.err));
                end
            end else begin
                check("idle_outputs", {31'd0, PSLVERR, PRDATA}, 64'd0);
            end
        end
    end

    task automatic bus(input logic sel, input logic en, input logic wr,
                       input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        @(posedge PCLK);
        #1;
        PSEL = sel; PENABLE = en; PWRITE = wr; PADDR = a; PWDATA = d;
    endtask

    function automatic int sat(input int n);
        return (n > 255) ? 255 : n;
    endfunction

    // kind: 0 normal, 1 PENABLE drop at access cycle j, 2 PSEL drop at j,
    // 3 PADDR change from j, 4 PADDR change then PENABLE drop at j, 5 PWDATA change from j.
    task automatic xfer(input logic wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                        input int kind, input int j, input bit b2b);
        int                idx;
        bit                chg;
        bit                abort;
        logic [ADDR_W-1:0] ca;
        logic [DATA_W-1:0] cd;
        exp_t              x;
        idx   = int'(a[ADDR_W-1:2]);
        chg   = (kind == 3) || (kind == 4) || (kind == 5 && wr);
        abort = (kind == 1) || (kind == 2) || (kind == 4);
        ca = a;
        cd = d;
        bus(1'b1, 1'b0, wr, a, d);
        if (chg) begin
            m_flags[2] = 1'b1;
            m_cnt++;
        end
        if (abort) begin
            m_flags[(kind == 2) ? 3 : 1] = 1'b1;
            m_cnt++;
        end else begin
            x.cyc  = cyc + 1 + WS;
            x.err  = (idx >= DEPTH) || chg;
            x.data = (!wr && !x.err) ? m_mem[idx] : 32'd0;
            if (wr && !x.err) m_mem[idx] = d;
            sb_q.push_back(x);
        end
        for (int k = 0; k <= WS; k++) begin
            if ((kind == 3 && k == j) || (kind == 4 && k == 0)) ca = a ^ 9'h004;
            if (kind == 5 && k == j) cd = ~d;
            if ((kind == 1 || kind == 4) && k == j) begin
                bus(1'b1, 1'b0, wr, ca, cd);
                break;
            end
            if (kind == 2 && k == j) begin
                bus(1'b0, 1'b0, wr, ca, cd);
                break;
            end
            bus(1'b1, 1'b1, wr, ca, cd);
        end
        if (!b2b) bus(1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic no_setup(input int n);
        for (int i = 0; i < n; i++) bus(1'b1, 1'b1, 1'b0, 9'h004, 32'd0);
        bus(1'b0, 1'b0, 1'b0, '0, '0);
        m_flags[0] = 1'b1;
        m_cnt += n;
    endtask

    task automatic status(input string tag);
        bus(1'b0, 1'b0, 1'b0, '0, '0);
        check({tag, "_flags"}, 64'(viol_flags), 64'(m_flags));
        check({tag, "_count"}, 64'(viol_count), 64'(sat(m_cnt)));
    endtask

    task automatic clr_cycle(input bit with_viol);
        @(posedge PCLK);
        #1;
        viol_clr = 1'b1; PSEL = with_viol; PENABLE = with_viol;
        @(posedge PCLK);
        #1;
        viol_clr = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
        m_flags = 4'd0;
        m_cnt   = 0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'd0;
        m_flags = 4'd0;
        m_cnt   = 0;
    endtask

    initial begin
        int                r;
        int                kind;
        logic [ADDR_W-1:0] a;
        logic [6:0]        ri;
        model_reset();
        repeat (3) @(posedge PCLK);
        #1;
        check("rst_pready", 64'(PREADY), 64'd0);
        check("rst_pslverr", 64'(PSLVERR), 64'd0);
        check("rst_prdata", 64'(PRDATA), 64'd0);
        check("rst_flags", 64'(viol_flags), 64'd0);
        check("rst_count", 64'(viol_count), 64'd0);
        PRESETn = 1'b1;

        xfer(1'b1, 9'h004, 32'hA5A5_0001, 0, 0, 1'b0);
        xfer(1'b0, 9'h004, 32'd0, 0, 0, 1'b0);
        xfer(1'b1, 9'h008, 32'h0BAD_F00D, 0, 0, 1'b1);
        xfer(1'b0, 9'h008, 32'd0, 0, 0, 1'b0);
        status("clean");

        no_setup(1);
        status("no_setup");
        xfer(1'b0, 9'h004, 32'd0, 0, 0, 1'b0);

        xfer(1'b1, 9'h00C, 32'h1111_2222, 1, 1, 1'b0);
        xfer(1'b0, 9'h00C, 32'd0, 0, 0, 1'b0);
        status("en_drop");
        xfer(1'b1, 9'h010, 32'h3333_4444, 3, 1, 1'b0);
        xfer(1'b0, 9'h010, 32'd0, 0, 0, 1'b0);
        status("ctrl_chg");
        xfer(1'b1, 9'h018, 32'h5555_6666, 5, 2, 1'b0);
        xfer(1'b1, 9'h01C, 32'h7777_8888, 2, 0, 1'b0);
        xfer(1'b1, 9'h020, 32'h9999_AAAA, 4, 2, 1'b0);
        xfer(1'b0, 9'h020, 32'd0, 0, 0, 1'b0);
        status("multi");
        xfer(1'b0, 9'h100, 32'd0, 0, 0, 1'b0);
        xfer(1'b1, 9'h1FC, 32'hDEAD_BEEF, 0, 0, 1'b0);
        status("out_of_range");

        clr_cycle(1'b0);
        status("clr");
        no_setup(300);
        status("saturate");
        clr_cycle(1'b1);
        status("clr_priority");

        for (int t = 0; t < 200; t++) begin
            r  = $urandom_range(0, 11);
            ri = ($urandom_range(0, 7) == 0) ? 7'(64 + $urandom_range(0, 63)) : 7'($urandom_range(0, 15));
            a  = {ri, 2'($urandom_range(0, 3))};
            if (r >= 11) begin
                no_setup($urandom_range(1, 3));
            end else begin
                kind = (r <= 5) ? 0 : r - 5;
                xfer(1'($urandom_range(0, 1)), a, $urandom, kind,
                     (kind == 4) ? $urandom_range(1, WS) : $urandom_range(0, WS),
                     1'($urandom_range(0, 1)));
            end
            if (t % 20 == 19) status("random");
        end

        // Reset pulled on what would be the completing cycle of a write.
        bus(1'b1, 1'b0, 1'b1, 9'h014, 32'h1234_5678);
        for (int k = 0; k <= WS; k++) bus(1'b1, 1'b1, 1'b1, 9'h014, 32'h1234_5678);
        check("pready_before_reset", 64'(PREADY), 64'd1);
        #1;
        PRESETn = 1'b0;
        #1;
        check("pready_in_reset", 64'(PREADY), 64'd0);
        check("pslverr_in_reset", 64'(PSLVERR), 64'd0);
        bus(1'b0, 1'b0, 1'b0, '0, '0);
        PRESETn = 1'b1;
        model_reset();
        status("after_reset");
        xfer(1'b0, 9'h014, 32'd0, 0, 0, 1'b0);
        xfer(1'b0, 9'h008, 32'd0, 0, 0, 1'b0);
        repeat (3) bus(1'b0, 1'b0, 1'b0, '0, '0);
        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
